// File: rtl/irq_ctrl.sv
// Machine interrupt controller: synchronised, edge-detected external lines plus an
// mtime/mtimecmp timer, fixed-priority arbitration and a held request until acknowledged.
module irq_ctrl #(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  irq_src,
  input  logic             mstatus_mie,
  input  logic             mie_mtie,
  input  logic             mie_meie,
  output logic             interrupt,
  output logic [31:0]      irq_cause,
  input  logic             irq_ack,
  input  logic             mmio_we,
  input  logic [3:0]       mmio_addr,
  input  logic [31:0]      mmio_wdata,
  output logic [31:0]      mmio_rdata
);

  localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
  logic [NSRC-1:0] sync_prev_q, sync_prev_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [31:0]     mtime_q, mtime_d;
  logic [31:0]     mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  state_e          state_q, state_d;
  logic [IW-1:0]   sel_id_q, sel_id_d;
  logic            sel_timer_q, sel_timer_d;
  logic            interrupt_q, interrupt_d;
  logic [31:0]     irq_cause_q, irq_cause_d;

  logic [NSRC-1:0] rise_c, ext_ok_c;
  logic            timer_pend_c, timer_ok_c, any_ok_c, ack_clr_c;
  logic [IW-1:0]   win_id_c;
  logic [31:0]     win_cause_c;
  logic            wr_mtime_c, wr_mtimecmp_c, wr_pend_c, wr_en_c;
  logic            unused_addr_c;

  assign unused_addr_c = ^mmio_addr[1:0];

  assign wr_mtime_c    = mmio_we && (mmio_addr[3:2] == 2'd0);
  assign wr_mtimecmp_c = mmio_we && (mmio_addr[3:2] == 2'd1);
  assign wr_pend_c     = mmio_we && (mmio_addr[3:2] == 2'd2);
  assign wr_en_c       = mmio_we && (mmio_addr[3:2] == 2'd3);

  // Synchroniser chain and rising-edge detect on the synchronised value
  always_comb begin
    sync_d    = '0;
    sync_d[0] = irq_src;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
    sync_prev_d = sync_q[SYNC_STAGES-1];
    rise_c      = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  end

  // Machine timer; a software write to mtime restarts the prescale phase
  always_comb begin
    pcnt_d  = pcnt_q + PW'(1);
    mtime_d = mtime_q;
    if (pcnt_q == PW'(PRESCALE - 1)) begin
      pcnt_d  = '0;
      mtime_d = mtime_q + 32'd1;
    end
    if (wr_mtime_c) begin
      pcnt_d  = '0;
      mtime_d = mmio_wdata;
    end
    mtimecmp_d = wr_mtimecmp_c ? mmio_wdata : mtimecmp_q;
    enable_d   = wr_en_c ? mmio_wdata[NSRC-1:0] : enable_q;
  end

  assign timer_pend_c = (mtime_q >= mtimecmp_q);

  // Fixed priority: timer first, then the lowest-numbered external line
  always_comb begin
    ext_ok_c   = pending_q & enable_q & {NSRC{mie_meie & mstatus_mie}};
    timer_ok_c = timer_pend_c & mie_mtie & mstatus_mie;
    any_ok_c   = timer_ok_c | (|ext_ok_c);
    win_id_c   = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (ext_ok_c[i]) win_id_c = IW'(i);
    end
    win_cause_c = timer_ok_c ? CAUSE_TIMER : (CAUSE_EXT | (32'(win_id_c) << 16));
  end

  // Request FSM; cause is frozen while the request is outstanding
  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    irq_cause_d = irq_cause_q;
    sel_id_d    = sel_id_q;
    sel_timer_d = sel_timer_q;
    ack_clr_c   = 1'b0;
    case (state_q)
      IDLE: begin
        interrupt_d = 1'b0;
        if (any_ok_c) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          irq_cause_d = win_cause_c;
          sel_id_d    = win_id_c;
          sel_timer_d = timer_ok_c;
        end
      end
      REQ: begin
        interrupt_d = 1'b1;
        if (irq_ack) begin
          ack_clr_c   = ~sel_timer_q;
          state_d     = WAIT;
          interrupt_d = 1'b0;
        end else if (!mstatus_mie) begin
          state_d     = IDLE;
          interrupt_d = 1'b0;
        end
      end
      WAIT: begin
        interrupt_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        interrupt_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Pending bits: new edges override any clear in the same cycle
  always_comb begin
    pending_d = pending_q;
    if (wr_pend_c) pending_d = pending_d & ~mmio_wdata[NSRC-1:0];
    if (ack_clr_c) pending_d[sel_id_q] = 1'b0;
    pending_d = pending_d | rise_c;
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr[3:2])
      2'd0: mmio_rdata = mtime_q;
      2'd1: mmio_rdata = mtimecmp_q;
      2'd2: begin
        mmio_rdata     = 32'(pending_q);
        mmio_rdata[31] = timer_pend_c;
      end
      2'd3: mmio_rdata = 32'(enable_q);
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      sync_prev_q <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      pcnt_q      <= '0;
      state_q     <= IDLE;
      sel_id_q    <= '0;
      sel_timer_q <= 1'b0;
      interrupt_q <= 1'b0;
      irq_cause_q <= '0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      pcnt_q      <= pcnt_d;
      state_q     <= state_d;
      sel_id_q    <= sel_id_d;
      sel_timer_q <= sel_timer_d;
      interrupt_q <= interrupt_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_cause = irq_cause_q;

endmodule
